reg_file: RTL and testbench

Integer register file for the MIPS datapath: 32 registers of 32 bits, two combinational read ports and one synchronous write port. It sits in the decode/write-back stage. Register 0 always reads as zero, per MIPS `$zero`. An asynchronous active-low reset clears the whole array.

---
 rtl/reg_file.sv | 45 ++++
 tb/tb_reg_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: MIPS integer register file, 32 x 32 bits.
// Two combinational read ports and one write port on the rising clock edge.
// r0 is hardwired to zero and has no storage. Reset is asynchronous and
// active-low, and clears r1..r31.
module reg_file (
    input  logic        clock,
    input  logic        Reset,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    input  logic [4:0]  WriteAddr,
    input  logic [31:0] WriteData,
    input  logic        RegWrite,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    // Only r1..r31 are stored; index 0 is decoded away on both paths.
    logic [31:0] regArray [31:1];

    // Array update: an asynchronous clear takes priority over writes, and
    // writes to r0 are dropped.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regArray[i] <= '0;
            end
        end else if (RegWrite && (WriteAddr != 5'd0)) begin
            regArray[WriteAddr] <= WriteData;
        end
    end

    // Read ports: combinational and independent, with r0 forced to zero and
    // no bypass from the write port.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadAddr1 != 5'd0) begin
            ReadData1 = regArray[ReadAddr1];
        end
        if (ReadAddr2 != 5'd0) begin
            ReadData2 = regArray[ReadAddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file.
// The stimulus process drives one operation per cycle just after the rising
// edge. It queues the read values it expects from a plain array model, and
// the monitor checks them at the falling edge.
module tb_reg_file;

    logic        clock;
    logic        Reset;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    reg_file dut (
        .clock     (clock),
        .Reset     (Reset),
        .ReadAddr1 (ReadAddr1),
        .ReadAddr2 (ReadAddr2),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } expect_t;

    expect_t     expQ[$];
    logic [31:0] model [32];
    int          total = 0;
    int          bad   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: at each falling edge, compare every queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                check({e.name, "/rd1"}, ReadData1, e.exp1);
                check({e.name, "/rd2"}, ReadData2, e.exp2);
            end
        end
    end

    function automatic void pushExpect(input string nm);
        expect_t e;
        e.name = nm;
        e.exp1 = model[ReadAddr1];
        e.exp2 = model[ReadAddr2];
        expQ.push_back(e);
    endfunction

    // One cycle, entered and left at 1 time unit after a rising edge. The
    // expectation uses the pre-edge model, and the write lands after the edge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2, input string nm);
        RegWrite  = we;
        WriteAddr = wa;
        WriteData = wd;
        ReadAddr1 = ra1;
        ReadAddr2 = ra2;
        pushExpect(nm);
        @(posedge clock);
        if (Reset && we && wa != 5'd0) model[wa] = wd;
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Pull Reset low between edges. The falling-edge check then sees zeros
    // with no rising edge in between, and Reset is released before the next
    // rising edge.
    task automatic midReset(input logic [4:0] ra1, input logic [4:0] ra2, input string nm);
        RegWrite  = 1'b0;
        ReadAddr1 = ra1;
        ReadAddr2 = ra2;
        #1;
        Reset = 1'b0;
        clearModel();
        #1;
        pushExpect(nm);
        @(negedge clock);
        #1;
        Reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned n;
        logic [4:0]  wa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;

        clearModel();
        Reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteAddr = '0;
        WriteData = '0;
        ReadAddr1 = '0;
        ReadAddr2 = '0;
        @(posedge clock);
        #1;

        // Reset held across edges, including a write attempt that must be ignored.
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, "reset_r0_r1");
        cycle(1'b1, 5'd31, 32'h5555AAAA, 5'd31, 5'd31, "reset_r31_wr");
        Reset = 1'b1;
        cycle(1'b0, 5'd0, 32'h0, 5'd31, 5'd1, "after_reset");

        // Directed cases.
        cycle(1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd0, "wr_r1");
        cycle(1'b0, 5'd1, 32'h0, 5'd1, 5'd1, "rd_r1");
        cycle(1'b1, 5'd2, 32'hCAFEBABE, 5'd1, 5'd2, "wr_r2");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "rd_r1_r2");
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr_r0");
        cycle(1'b0, 5'd3, 32'h12345678, 5'd0, 5'd3, "rd_r0_noen");
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, "rd_r3");
        cycle(1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, "wr_r5_old");
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "wr_r5_new");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "pre_midreset");
        midReset(5'd1, 5'd2, "midreset");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd5, "post_midreset");
        cycle(1'b1, 5'd31, 32'h80000001, 5'd31, 5'd2, "wr_r31");
        cycle(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "rd_r31");

        // Random traffic, with reads often aimed at the write target.
        for (int i = 0; i < 400; i++) begin
            n   = $urandom_range(0, 99);
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if (n < 3) begin
                midReset(ra1, ra2, "rand_reset");
            end else begin
                cycle(n < 70, wa, $urandom(), ra1, ra2, "rand");
            end
        end

        // Give the monitor a bounded time to drain the queue.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
        if (expQ.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
